// File: rtl/operand_fetch_pkg.sv
// Shared widths, the hardwired-zero register index and the operand-entry layout
// for the operand fetch stage.
package operand_fetch_pkg;
  localparam int OF_DATA_W = 32;
  localparam int OF_ADDR_W = 5;
  localparam logic [OF_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [OF_ADDR_W-1:0] rs1;
    logic [OF_ADDR_W-1:0] rs2;
    logic [OF_ADDR_W-1:0] rd;
    logic [OF_DATA_W-1:0] op_a;
    logic [OF_DATA_W-1:0] op_b;
  } op_entry_t;
endpackage

// File: rtl/operand_select.sv
// Resolves one operand: register read (load=1) or held value (load=0),
// then write-back bypass (OPERAND_FETCH_BYPASS_EN) and the hardwired-zero override.
module operand_select
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W      = OF_DATA_W,
  parameter int ADDR_W      = OF_ADDR_W,
  parameter int HARDWIRE_R0 = 1
) (
  input  logic [DATA_W*(2**ADDR_W)-1:0] regs_flat,
  input  logic [ADDR_W-1:0]             rs,
  input  logic                          load,
  input  logic [DATA_W-1:0]             hold,
  input  logic                          wb_en,
  input  logic [ADDR_W-1:0]             wb_dest,
  input  logic [DATA_W-1:0]             wb_value,
  output logic [DATA_W-1:0]             op
);
  logic [2**ADDR_W-1:0][DATA_W-1:0] regs;
  logic                             is_r0;
  logic                             hit;
  logic [DATA_W-1:0]                base;

  assign regs  = regs_flat;
  assign is_r0 = (HARDWIRE_R0 != 0) && (rs == ADDR_W'(ZERO_REG));
  assign base  = load ? regs[rs] : hold;

`ifdef OPERAND_FETCH_BYPASS_EN
  assign hit = wb_en && (wb_dest == rs);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_dest, wb_value};
  assign hit       = 1'b0;
`endif

  // Zero override wins over bypass so %g0 can never pick up write-back data.
  always_comb begin
    op = base;
    if (is_r0)    op = '0;
    else if (hit) op = wb_value;
  end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: 2-entry operand queue between decode and execute, with
// optional write-back coherence of queued operands (OPERAND_FETCH_BYPASS_EN).
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W      = OF_DATA_W,
  parameter int ADDR_W      = OF_ADDR_W,
  parameter int HARDWIRE_R0 = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_W-1:0]             rs1,
  input  logic [ADDR_W-1:0]             rs2,
  input  logic [ADDR_W-1:0]             rd_in,
  input  logic [DATA_W*(2**ADDR_W)-1:0] regs_flat,
  input  logic                          wb_en,
  input  logic [ADDR_W-1:0]             wb_dest,
  input  logic [DATA_W-1:0]             wb_value,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             op_a,
  output logic [DATA_W-1:0]             op_b,
  output logic [ADDR_W-1:0]             rd_out
);
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
  } entry_t;

  entry_t [DEPTH-1:0]             q;
  logic                           rd_ptr, wr_ptr;
  logic [1:0]                     count;
  logic                           push, pop;
  logic [DATA_W-1:0]              push_a, push_b;
  logic [DEPTH-1:0][DATA_W-1:0]   upd_a, upd_b;
  logic [DEPTH-1:0]               slot_vld;
  entry_t                         new_e;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign op_a      = q[rd_ptr].op_a;
  assign op_b      = q[rd_ptr].op_b;
  assign rd_out    = q[rd_ptr].rd;

  operand_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HARDWIRE_R0(HARDWIRE_R0)) u_sel_a (
    .regs_flat(regs_flat), .rs(rs1), .load(1'b1), .hold('0),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .op(push_a));

  operand_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HARDWIRE_R0(HARDWIRE_R0)) u_sel_b (
    .regs_flat(regs_flat), .rs(rs2), .load(1'b1), .hold('0),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .op(push_b));

  // Per-slot coherence: the same selector, fed with the stored value as its base.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_vld[i] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'(i)));

    operand_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HARDWIRE_R0(HARDWIRE_R0)) u_upd_a (
      .regs_flat(regs_flat), .rs(q[i].rs1), .load(1'b0), .hold(q[i].op_a),
      .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .op(upd_a[i]));

    operand_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HARDWIRE_R0(HARDWIRE_R0)) u_upd_b (
      .regs_flat(regs_flat), .rs(q[i].rs2), .load(1'b0), .hold(q[i].op_b),
      .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .op(upd_b[i]));
  end

  always_comb begin
    new_e      = '0;
    new_e.rs1  = rs1;
    new_e.rs2  = rs2;
    new_e.rd   = rd_in;
    new_e.op_a = push_a;
    new_e.op_b = push_b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q      <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == 1'(i))) begin
          q[i] <= new_e;
        end else if (slot_vld[i]) begin
          q[i].op_a <= upd_a[i];
          q[i].op_b <= upd_b[i];
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch; expectations follow OPERAND_FETCH_BYPASS_EN.
module tb_operand_fetch;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk, reset;
  logic              in_valid, in_ready;
  logic [AW-1:0]     rs1, rs2, rd_in;
  logic [DW*32-1:0]  regs_flat;
  logic              wb_en;
  logic [AW-1:0]     wb_dest;
  logic [DW-1:0]     wb_value;
  logic              flush;
  logic              out_valid, out_ready;
  logic [DW-1:0]     op_a, op_b;
  logic [AW-1:0]     rd_out;

  int n_cmp = 0;
  int n_err = 0;

  operand_fetch #(.DATA_W(DW), .ADDR_W(AW), .HARDWIRE_R0(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd_in(rd_in), .regs_flat(regs_flat),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .rd_out(rd_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input int n, input logic [DW-1:0] v);
    regs_flat[n*DW +: DW] = v;
  endtask

  task automatic push_req(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d);
    in_valid = 1'b1; rs1 = a; rs2 = b; rd_in = d;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (op_a !== 32'h0) begin n_err++; $display("FAIL reset_op_a: got %h want 0", op_a); end
    n_cmp++; if (rd_out !== 5'd0) begin n_err++; $display("FAIL reset_rd_out: got %0d want 0", rd_out); end
    @(negedge clk); reset = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_basic_read();
    set_reg(3, 32'h1111_0003); set_reg(7, 32'h2222_0007);
    out_ready = 1'b0;
    push_req(5'd3, 5'd7, 5'd9);
    tick(); in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    n_cmp++; if (op_a !== 32'h1111_0003) begin n_err++; $display("FAIL basic_op_a: got %h want 11110003", op_a); end
    n_cmp++; if (op_b !== 32'h2222_0007) begin n_err++; $display("FAIL basic_op_b: got %h want 22220007", op_b); end
    n_cmp++; if (rd_out !== 5'd9) begin n_err++; $display("FAIL basic_rd: got %0d want 9", rd_out); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_zero_reg();
    set_reg(0, 32'hDEAD_BEEF);
    wb_en = 1'b1; wb_dest = 5'd0; wb_value = 32'h5;
    push_req(5'd0, 5'd0, 5'd1);
    tick(); in_valid = 1'b0;
    n_cmp++; if (op_a !== 32'h0) begin n_err++; $display("FAIL zero_op_a: got %h want 0", op_a); end
    n_cmp++; if (op_b !== 32'h0) begin n_err++; $display("FAIL zero_op_b: got %h want 0", op_b); end
    tick(); wb_en = 1'b0;
    n_cmp++; if (op_a !== 32'h0) begin n_err++; $display("FAIL zero_held: got %h want 0", op_a); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    set_reg(1, 32'h11); set_reg(2, 32'h22); set_reg(5, 32'h55);
    out_ready = 1'b0;
    push_req(5'd1, 5'd0, 5'd1); tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1: got %0b want 1", in_ready); end
    push_req(5'd2, 5'd0, 5'd2); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got %0b want 0", in_ready); end
    push_req(5'd5, 5'd0, 5'd5); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_held_ready: got %0b want 0", in_ready); end
    n_cmp++; if (rd_out !== 5'd1 || op_a !== 32'h11) begin n_err++; $display("FAIL bp_head_a: got rd %0d op %h want rd 1 op 11", rd_out, op_a); end
    out_ready = 1'b1; tick();
    n_cmp++; if (rd_out !== 5'd2 || op_a !== 32'h22) begin n_err++; $display("FAIL bp_head_b: got rd %0d op %h want rd 2 op 22", rd_out, op_a); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_reopen: got %0b want 1", in_ready); end
    tick(); in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || rd_out !== 5'd5 || op_a !== 32'h55) begin n_err++; $display("FAIL bp_head_c: got v %0b rd %0d op %h want v 1 rd 5 op 55", out_valid, rd_out, op_a); end
    tick(); out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %0b want 0", out_valid); end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp;
    set_reg(4, 32'h4444); set_reg(6, 32'h66);
    out_ready = 1'b0;
    wb_en = 1'b1; wb_dest = 5'd4; wb_value = 32'hABCD;
    push_req(5'd4, 5'd6, 5'd3); tick();
    in_valid = 1'b0; wb_en = 1'b0;
    exp = BYP ? 32'hABCD : 32'h4444;
    n_cmp++; if (op_a !== exp) begin n_err++; $display("FAIL byp_push: got %h want %h", op_a, exp); end
    n_cmp++; if (op_b !== 32'h66) begin n_err++; $display("FAIL byp_op_b: got %h want 66", op_b); end
    tick();
    n_cmp++; if (op_a !== exp) begin n_err++; $display("FAIL byp_hold: got %h want %h", op_a, exp); end
    wb_en = 1'b1; wb_dest = 5'd4; wb_value = 32'h1234; set_reg(4, 32'h1234);
    tick(); wb_en = 1'b0;
    exp = BYP ? 32'h1234 : 32'h4444;
    n_cmp++; if (op_a !== exp) begin n_err++; $display("FAIL byp_update: got %h want %h", op_a, exp); end
    wb_en = 1'b1; wb_dest = 5'd4; wb_value = 32'h9999;
    push_req(5'd4, 5'd6, 5'd8); tick();
    in_valid = 1'b0; wb_en = 1'b0;
    exp = BYP ? 32'h9999 : 32'h4444;
    n_cmp++; if (op_a !== exp) begin n_err++; $display("FAIL byp_same_head: got %h want %h", op_a, exp); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    exp = BYP ? 32'h9999 : 32'h1234;
    n_cmp++; if (rd_out !== 5'd8 || op_a !== exp) begin n_err++; $display("FAIL byp_same_push: got rd %0d op %h want rd 8 op %h", rd_out, op_a, exp); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL byp_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push_req(5'd3, 5'd7, 5'd1); tick();
    push_req(5'd3, 5'd7, 5'd2); tick();
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL flush_fill: got r %0b v %0b want r 0 v 1", in_ready, out_valid); end
    flush = 1'b1; push_req(5'd3, 5'd7, 5'd3); tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_full: got v %0b r %0b want v 0 r 1", out_valid, in_ready); end
    push_req(5'd3, 5'd7, 5'd4); tick();
    flush = 1'b1; push_req(5'd3, 5'd7, 5'd5); tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_push_dropped: got %0b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stays_empty: got %0b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    push_req(5'd3, 5'd7, 5'd9); tick(); in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || rd_out !== 5'd9) begin n_err++; $display("FAIL arst_pre: got v %0b rd %0d want v 1 rd 9", out_valid, rd_out); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %0b want 0", out_valid); end
    n_cmp++; if (op_a !== 32'h0 || op_b !== 32'h0 || rd_out !== 5'd0) begin n_err++; $display("FAIL arst_outputs: got a %h b %h rd %0d want 0", op_a, op_b, rd_out); end
    #1 reset = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL arst_after: got v %0b r %0b want v 0 r 1", out_valid, in_ready); end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd_in = '0;
    regs_flat = '0; wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic_read();
    test_zero_reg();
    test_backpressure();
    test_bypass();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side counterpart of the write-back register file. Takes decoded source-register indices, reads operands from the flattened architectural register bus, and presents them to execute.
- Sits between decode and execute, opposite the write-back stage.
- Uses a 2-entry operand queue with valid/ready handshakes on both sides.
- Buffered entries are kept coherent with in-flight write-backs.

Parameters:
- DATA_W, 32, register/operand width
- ADDR_W, 5, register index width; register count = 2**ADDR_W
- HARDWIRE_R0, 1, when 1 index 0 always reads 0 (SPARC %g0)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- in_valid  input  1  decode presents a request
- in_ready  output  1  queue can accept a request
- rs1  input  ADDR_W  source register A index
- rs2  input  ADDR_W  source register B index
- rd_in  input  ADDR_W  destination index, passed through unchanged
- regs_flat  input  DATA_W*2**ADDR_W  register file contents; Rn at bits [n*DATA_W +: DATA_W]
- wb_en  input  1  write-back commits this cycle
- wb_dest  input  ADDR_W  write-back target index
- wb_value  input  DATA_W  write-back data
- flush  input  1  discard all queued requests
- out_valid  output  1  head entry valid
- out_ready  input  1  execute accepts head
- op_a  output  DATA_W  head operand A
- op_b  output  DATA_W  head operand B
- rd_out  output  ADDR_W  head destination index

Behaviour:
- Reset (reset=0, asynchronous) clears entries, count, op_a, op_b and rd_out to 0, and drives out_valid=0. in_ready=1 once reset is released.
- Queue depth is 2, with count 0..2. in_ready = (count<2). in_ready is combinational from count only, never from out_ready; there is no same-cycle pass-through when full.
- Push occurs when in_valid&&in_ready. The entry is captured at the clock edge with op = regs_flat[rs] (subject to bypass and R0 rules). Latency is 1 cycle: out_valid rises the cycle after the push when the queue was empty.
- Pop occurs when out_valid&&out_ready. The head advances at the clock edge. Simultaneous push and pop leaves count unchanged and keeps order FIFO.
- out_valid = (count>0). op_a, op_b and rd_out come straight from the head entry registers.
- R0 rule: if HARDWIRE_R0=1 and rs==0, the operand is 0 regardless of regs_flat or bypass. Stored entries with source 0 are never updated.
- Each entry stores rs1 and rs2 alongside its operands, for coherence updates.
- flush=1: count becomes 0 at the next edge and any push or pop in that cycle is ignored. in_ready stays as computed from the current count.
- A mid-operation reset discards all entries immediately; no partial state survives.
- All arithmetic is unsigned. Pointers are 1 bit and wrap 1 to 0.

Optional Feature:
- Macro: OPERAND_FETCH_BYPASS_EN
- Defined:
  - On push, if wb_en && wb_dest==rs (and not the hardwired R0 case), the operand takes wb_value instead of regs_flat.
  - Every cycle, each valid stored entry whose rs1/rs2 matches wb_dest with wb_en=1 overwrites that operand with wb_value. This keeps queued operands coherent.
  - A push and an update to the same register in the same cycle both yield wb_value.
- Not defined:
  - Operands are sampled from regs_flat only at push.
  - Stored entries are never updated; execute sees values from the push cycle.
  - wb_en, wb_dest and wb_value are unused.

Decomposition:
- Shared package holds DATA_W/ADDR_W defaults, the ZERO_REG index constant, and an operand-entry struct {rs1, rs2, rd, op_a, op_b}.
- One sub-module is natural: operand_select. It is combinational and handles index decode from regs_flat, the bypass compare and the R0 override. Instantiated once per source port and shared with the entry-update logic.

Test Plan:
- Reset/basic read: set regs_flat R3=0x1111_0003, R7=0x2222_0007. Push rs1=3, rs2=7, rd=9. Next cycle: out_valid=1, op_a=0x1111_0003, op_b=0x2222_0007, rd_out=9.
- Zero register: R0 in regs_flat=0xDEAD_BEEF. Push rs1=0, rs2=0 -> op_a=op_b=0. With the macro, wb_en=1, wb_dest=0, wb_value=5 still gives 0.
- Backpressure/full: out_ready=0 with 3 pushes. First two accepted, in_ready=0 after the second, third held. Raise out_ready: entries drain in order and the third is accepted the cycle count drops.
- Bypass (macro on): push rs1=4 while wb_en=1, wb_dest=4, wb_value=0xABCD -> op_a=0xABCD. Hold entry with out_ready=0, then write 0x1234 to R4 -> op_a becomes 0x1234 next cycle.
- Bypass (macro off): same stimulus -> op_a equals the regs_flat R4 value at push and never changes while queued.
- Flush and async reset: fill 2 entries and assert flush with in_valid=1 -> count=0, out_valid=0 next cycle, nothing queued. Refill and pulse reset low mid-cycle -> out_valid and op_a/op_b/rd_out go 0 immediately.
